// File: rtl/time_pkg.sv
// Shared types and constants for the time-programming controller.
package time_pkg;

  typedef enum logic [1:0] {
    ST_EDIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] DIG_S  = 2'd0;
  localparam logic [1:0] DIG_TS = 2'd1;
  localparam logic [1:0] DIG_M  = 2'd2;
  localparam logic [1:0] DIG_TM = 2'd3;

  localparam logic [3:0] SEC_MAX  = 4'd9;
  localparam logic [3:0] TSEC_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX  = 4'd9;

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit increment/decrement with wrap at 0 and max_val.
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic [3:0] max_val,
  input  logic       up,
  output logic [3:0] next_digit
);

  // Up wraps max->0, down wraps 0->max; no carry out.
  always_comb begin
    next_digit = digit;
    if (up) begin
      next_digit = (digit >= max_val) ? '0 : digit + 4'd1;
    end else begin
      next_digit = (digit == '0) ? max_val : digit - 4'd1;
    end
  end

endmodule

// File: rtl/time_program.sv
// Button-driven editor for the BCD start time, plus run/pause/done control
// of the downstream countdown.
module time_program
  import time_pkg::*;
#(
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1000000,
  parameter logic [3:0]  TENS_MIN_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       count_zero,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic [1:0] digit_sel,
  output logic       load,
  output logic       timer_on,
  output logic       alarm
);

  state_t state, next_state;

  logic prev_sel, prev_up, prev_down, prev_start, edge_en;
  logic sel_rise, up_rise, down_rise, start_rise;

  logic [3:0][3:0] digits;
  logic [3:0][3:0] stepped;
  logic            digits_zero;

  logic [23:0] rpt_cnt, rpt_cnt_next;
  logic        rpt_phase, rpt_phase_next;
  logic        step_req;

  logic load_next, timer_on_next, alarm_next;

  // edge_en masks the first cycle after reset so a button held through
  // reset release is captured into prev_* without producing a rise.
  assign sel_rise   = edge_en & btn_sel   & ~prev_sel;
  assign up_rise    = edge_en & btn_up    & ~prev_up;
  assign down_rise  = edge_en & btn_down  & ~prev_down;
  assign start_rise = edge_en & btn_start & ~prev_start;

  assign digits_zero = (digits == '0);

  assign seconds_prog      = digits[DIG_S];
  assign tens_seconds_prog = digits[DIG_TS];
  assign minutes_prog      = digits[DIG_M];
  assign tens_minutes_prog = digits[DIG_TM];

  bcd_digit_step u_step_s (
    .digit      (digits[DIG_S]),
    .max_val    (SEC_MAX),
    .up         (btn_up),
    .next_digit (stepped[DIG_S])
  );

  bcd_digit_step u_step_ts (
    .digit      (digits[DIG_TS]),
    .max_val    (TSEC_MAX),
    .up         (btn_up),
    .next_digit (stepped[DIG_TS])
  );

  bcd_digit_step u_step_m (
    .digit      (digits[DIG_M]),
    .max_val    (MIN_MAX),
    .up         (btn_up),
    .next_digit (stepped[DIG_M])
  );

  bcd_digit_step u_step_tm (
    .digit      (digits[DIG_TM]),
    .max_val    (TENS_MIN_MAX),
    .up         (btn_up),
    .next_digit (stepped[DIG_TM])
  );

  // Button history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sel   <= 1'b0;
      prev_up    <= 1'b0;
      prev_down  <= 1'b0;
      prev_start <= 1'b0;
      edge_en    <= 1'b0;
    end else begin
      prev_sel   <= btn_sel;
      prev_up    <= btn_up;
      prev_down  <= btn_down;
      prev_start <= btn_start;
      edge_en    <= 1'b1;
    end
  end

  // Auto-repeat: rpt_phase=0 waits REPEAT_DELAY after the press, then
  // rpt_phase=1 re-arms every REPEAT_RATE; the counter restarts at 1 on
  // each step so both intervals are plain compares.
  always_comb begin
    rpt_cnt_next   = rpt_cnt;
    rpt_phase_next = rpt_phase;
    step_req       = 1'b0;
    if (state != ST_EDIT || !(btn_up ^ btn_down)) begin
      rpt_cnt_next   = '0;
      rpt_phase_next = 1'b0;
    end else if (up_rise || down_rise) begin
      rpt_cnt_next   = 24'd1;
      rpt_phase_next = 1'b0;
      step_req       = 1'b1;
    end else if (rpt_cnt != '0) begin
      if (!rpt_phase && rpt_cnt == REPEAT_DELAY) begin
        step_req       = 1'b1;
        rpt_phase_next = 1'b1;
        rpt_cnt_next   = 24'd1;
      end else if (rpt_phase && rpt_cnt == REPEAT_RATE) begin
        step_req     = 1'b1;
        rpt_cnt_next = 24'd1;
      end else if (rpt_cnt != '1) begin
        rpt_cnt_next = rpt_cnt + 24'd1;
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_next;
      rpt_phase <= rpt_phase_next;
    end
  end

  // Digit editing; a start press in EDIT takes priority over any edit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits    <= '0;
      digit_sel <= DIG_S;
    end else if (state == ST_EDIT && !start_rise) begin
      if (sel_rise) begin
        digit_sel <= digit_sel + 2'd1;
      end else if (step_req) begin
        digits[digit_sel] <= stepped[digit_sel];
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_EDIT: begin
        if (start_rise && !digits_zero) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (count_zero)      next_state = ST_DONE;
        else if (start_rise) next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (start_rise)    next_state = ST_RUN;
        else if (sel_rise) next_state = ST_EDIT;
      end
      ST_DONE: begin
        if (start_rise) next_state = ST_EDIT;
      end
      default: next_state = ST_EDIT;
    endcase
    load_next     = (state == ST_EDIT) && (next_state == ST_RUN);
    timer_on_next = (next_state == ST_RUN) && !load_next;
    alarm_next    = (next_state == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_EDIT;
      load     <= 1'b0;
      timer_on <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= next_state;
      load     <= load_next;
      timer_on <= timer_on_next;
      alarm    <= alarm_next;
    end
  end

endmodule

// File: tb/tb_time_program.sv
// Scoreboard bench for time_program: stimulus pushes model expectations,
// a monitor pops and compares after every clock edge.
module tb_time_program;

  localparam int         DELAY = 10;
  localparam int         RATE  = 4;
  localparam logic [3:0] TMAX  = 4'd9;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_sel, btn_up, btn_down, btn_start, count_zero;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic [1:0] digit_sel;
  logic       load, timer_on, alarm;

  time_program #(
    .REPEAT_DELAY (24'(DELAY)),
    .REPEAT_RATE  (24'(RATE)),
    .TENS_MIN_MAX (TMAX)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_sel           (btn_sel),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_start         (btn_start),
    .count_zero        (count_zero),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .digit_sel         (digit_sel),
    .load              (load),
    .timer_on          (timer_on),
    .alarm             (alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] s, ts, m, tm;
    logic [1:0] sel;
    logic       ld, ton, al;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: mode 0=edit 1=run 2=pause 3=done.
  int m_dig[4];
  int m_max[4];
  int m_sel, m_mode, m_age;
  bit m_first;
  bit p_sel, p_up, p_dn, p_st;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_max[0] = 9; m_max[1] = 5; m_max[2] = 9; m_max[3] = int'(TMAX);
    m_sel = 0; m_mode = 0; m_age = -1; m_first = 1'b1;
    p_sel = 0; p_up = 0; p_dn = 0; p_st = 0;
  endtask

  task automatic model_step(input bit s, input bit u, input bit d, input bit st, input bit cz);
    bit rs, ru, rd, rst, step, ld;
    exp_t e;
    rs  = s  && !p_sel && !m_first;
    ru  = u  && !p_up  && !m_first;
    rd  = d  && !p_dn  && !m_first;
    rst = st && !p_st  && !m_first;
    m_first = 1'b0;
    step = 0;
    ld = 0;
    if (m_mode == 0) begin
      if (u == d) m_age = -1;
      else if (ru || rd) begin m_age = 0; step = 1; end
      else if (m_age >= 0) begin
        m_age++;
        if (m_age >= DELAY && (m_age - DELAY) % RATE == 0) step = 1;
      end
    end else m_age = -1;
    case (m_mode)
      0: begin
        if (rst) begin
          if (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] != 0) begin ld = 1; m_mode = 1; end
        end else if (rs) m_sel = (m_sel + 1) % 4;
        else if (step) begin
          if (u) m_dig[m_sel] = (m_dig[m_sel] + 1) % (m_max[m_sel] + 1);
          else   m_dig[m_sel] = (m_dig[m_sel] + m_max[m_sel]) % (m_max[m_sel] + 1);
        end
      end
      1: if (cz) m_mode = 3; else if (rst) m_mode = 2;
      2: if (rst) m_mode = 1; else if (rs) m_mode = 0;
      default: if (rst) m_mode = 0;
    endcase
    p_sel = s; p_up = u; p_dn = d; p_st = st;
    e.s = 4'(m_dig[0]); e.ts = 4'(m_dig[1]); e.m = 4'(m_dig[2]); e.tm = 4'(m_dig[3]);
    e.sel = 2'(m_sel);
    e.ld  = ld;
    e.ton = (m_mode == 1) && !ld;
    e.al  = (m_mode == 3);
    q.push_back(e);
  endtask

  task automatic cycle(input bit s, input bit u, input bit d, input bit st, input bit cz);
    @(negedge clk);
    btn_sel = s; btn_up = u; btn_down = d; btn_start = st; count_zero = cz;
    model_step(s, u, d, st, cz);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per clock edge while the queue holds any.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("seconds_prog", int'(seconds_prog), int'(e.s));
        chk("tens_seconds_prog", int'(tens_seconds_prog), int'(e.ts));
        chk("minutes_prog", int'(minutes_prog), int'(e.m));
        chk("tens_minutes_prog", int'(tens_minutes_prog), int'(e.tm));
        chk("digit_sel", int'(digit_sel), int'(e.sel));
        chk("load", int'(load), int'(e.ld));
        chk("timer_on", int'(timer_on), int'(e.ton));
        chk("alarm", int'(alarm), int'(e.al));
      end
    end
  end

  initial begin
    bit rs_l, ru_l, rd_l, rst_l;
    reset = 1'b0;
    btn_sel = 0; btn_up = 0; btn_down = 0; btn_start = 0; count_zero = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_digits", int'({seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog}), 0);
    chk("reset_ctrl", int'({digit_sel, load, timer_on, alarm}), 0);
    reset = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0, 0);

    // Start with all digits zero is ignored.
    cycle(0, 0, 0, 1, 0); settle();
    chk("zero_start_load", int'(load), 0);
    cycle(0, 0, 0, 0, 0); settle();
    chk("zero_start_timer", int'(timer_on), 0);

    // Wrap on tens_seconds.
    cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("ts_down_wrap", int'(tens_seconds_prog), 5);
    cycle(0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("ts_up_wrap", int'(tens_seconds_prog), 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("ts_down_again", int'(tens_seconds_prog), 5);
    chk("others_unchanged", int'({seconds_prog, minutes_prog, tens_minutes_prog}), 0);

    // Auto-repeat on seconds: steps at press, +10, +14, +18.
    repeat (3) begin cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0); end
    repeat (20) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0); settle();
    chk("autorepeat_seconds", int'(seconds_prog), 4);

    // minutes=1, then start loads for exactly one cycle.
    repeat (2) begin cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0); end
    cycle(0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("minutes_one", int'(minutes_prog), 1);
    cycle(0, 0, 0, 1, 0); settle();
    chk("load_strobe", int'({load, timer_on}), 2);
    cycle(0, 0, 0, 0, 0); settle();
    chk("run_after_load", int'({load, timer_on}), 1);

    // Pause, resume without load, then done.
    cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("paused", int'(timer_on), 0);
    cycle(0, 0, 0, 1, 0); settle();
    chk("resume", int'({load, timer_on}), 1);
    cycle(0, 0, 0, 0, 1); settle();
    chk("done", int'({alarm, timer_on}), 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("done_to_edit", int'(alarm), 0);

    // count_zero and start together in RUN: DONE wins.
    cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1); settle();
    chk("cz_beats_start", int'({alarm, timer_on}), 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0); settle();
    chk("retained", int'({seconds_prog, tens_seconds_prog, minutes_prog}), 12'h451);
    chk("edit_alarm_low", int'(alarm), 0);

    // Mid-edit reset with up held through release: no step afterwards.
    @(negedge clk);
    reset = 1'b0;
    btn_up = 1'b1;
    #1;
    chk("midreset_digits", int'({seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog}), 0);
    chk("midreset_ctrl", int'({digit_sel, load, timer_on, alarm}), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0); settle();
    chk("held_through_reset", int'(seconds_prog), 0);

    // Randomised level stimulus.
    rs_l = 0; ru_l = 0; rd_l = 0; rst_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0)  rs_l  = ~rs_l;
      if ($urandom_range(15) == 0) ru_l  = ~ru_l;
      if ($urandom_range(15) == 0) rd_l  = ~rd_l;
      if ($urandom_range(9) == 0)  rst_l = ~rst_l;
      cycle(rs_l, ru_l, rd_l, rst_l, $urandom_range(19) == 0);
    end
    cycle(0, 0, 0, 0, 0);
    settle();
    settle();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
